dummy_accelerator_issuer: RTL and testbench

Core-side initiator for dummy_accelerator_top. It accepts offloaded operations (rs1, imm, id, rd) from the core, registers them, and drives the accelerator's valid/ready request port with tag = {id, rd}. It collects tagged results from the accelerator's output port and returns them to core writeback. It also tracks in-flight IDs, bounds outstanding operations, and flags protocol errors and timeouts.

---
 rtl/dummy_accelerator_pkg.sv | 23 ++
 rtl/dummy_acc_pipe_reg.sv | 47 ++++
 rtl/updown_counter.sv | 30 +++
 rtl/dummy_accelerator_issuer.sv | 187 ++++++++++++++++++
 tb/tb_dummy_accelerator_issuer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dummy_accelerator_pkg.sv
// Shared types and sizing helpers for the dummy accelerator issuer.
//   acc_tag_t  : {id, rd} tag for the default ID/RD widths
//   CNT_W      : outstanding-counter width for the default credit limit
//   cnt_width  : the same sizing rule for any credit limit
package dummy_accelerator_pkg;

  localparam int unsigned DEF_ID_WIDTH        = 4;
  localparam int unsigned DEF_RD_WIDTH        = 5;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  localparam int unsigned CNT_W = $clog2(DEF_MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0] id;
    logic [DEF_RD_WIDTH-1:0] rd;
  } acc_tag_t;

  // Counter must hold the value max_outstanding itself, hence +1.
  function automatic int unsigned cnt_width(int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/dummy_acc_pipe_reg.sv
// One-entry valid/ready pipeline register with synchronous flush.
//   clk_i, rst_ni        : clock, async active-low reset
//   flush                : drop the held entry next cycle
//   in_valid / in_ready  : upstream handshake (in_valid must only be raised
//                          together with in_ready by the caller)
//   in_data              : upstream payload
//   out_valid / out_ready: downstream handshake
//   out_data             : held payload, stable while out_valid && !out_ready
module dummy_acc_pipe_reg #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_q;
  T     data_q;

  // Accept when empty or when the held entry leaves this same cycle.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // NOTE: the payload is reset as well, because every port of the block
  // must read 0 while reset is asserted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with synchronous clear.
//   clk_i, rst_ni : clock, async active-low reset
//   clr           : synchronous clear (priority over en)
//   en            : step the counter this cycle
//   dn            : step direction when en (1 = down, 0 = up)
//   count         : current value
module updown_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr,
  input  logic             en,
  input  logic             dn,
  output logic [WIDTH-1:0] count
);

  // NOTE: state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= dn ? count - WIDTH'(1) : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dummy_accelerator_issuer.sv
// Core-side initiator for dummy_accelerator_top.
//   issue_*   : core request (rs1, imm, id, rd) with valid/ready
//   acc_*_o   : request to the accelerator, tag = {id, rd}
//   acc_*_i   : tagged result from the accelerator, acc_ready_o back
//   wb_*      : result returned to core writeback with valid/ready
//   outstanding_o : accepted-but-unreturned operations
//   busy_o    : work in flight or writeback pending
//   err_o     : sticky, a result arrived for an ID that was not in flight
//   timeout_o : sticky, no result for TIMEOUT_CYCLES-1 cycles while busy
//   flush_i   : synchronous flush, overrides everything
module dummy_accelerator_issuer
  import dummy_accelerator_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned IMM_WIDTH       = 11,
  parameter int unsigned ID_WIDTH        = DEF_ID_WIDTH,
  parameter int unsigned RD_WIDTH        = DEF_RD_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned OUT_W          = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [WIDTH-1:0]             issue_rs1_i,
  input  logic [IMM_WIDTH-1:0]         issue_imm_i,
  input  logic [ID_WIDTH-1:0]          issue_id_i,
  input  logic [RD_WIDTH-1:0]          issue_rd_i,
  output logic                         acc_valid_o,
  input  logic                         acc_ready_i,
  output logic [WIDTH-1:0]             acc_rs1_o,
  output logic [IMM_WIDTH-1:0]         acc_imm_o,
  output logic [ID_WIDTH+RD_WIDTH-1:0] acc_tag_o,
  input  logic                         acc_valid_i,
  output logic                         acc_ready_o,
  input  logic [WIDTH-1:0]             acc_result_i,
  input  logic [ID_WIDTH+RD_WIDTH-1:0] acc_tag_i,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic [WIDTH-1:0]             wb_data_o,
  output logic [RD_WIDTH-1:0]          wb_rd_o,
  output logic [ID_WIDTH-1:0]          wb_id_o,
  output logic [OUT_W-1:0]             outstanding_o,
  output logic                         busy_o,
  output logic                         err_o,
  output logic                         timeout_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // Same layout as acc_tag_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [RD_WIDTH-1:0] rd;
  } tag_t;

  typedef struct packed {
    logic [WIDTH-1:0]     rs1;
    logic [IMM_WIDTH-1:0] imm;
    tag_t                 tag;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0]    data;
    logic [RD_WIDTH-1:0] rd;
    logic [ID_WIDTH-1:0] id;
  } res_t;

  logic [2**ID_WIDTH-1:0] inflight_q;
  logic [OUT_W-1:0]       count;
  logic [WD_W-1:0]        wd_q;
  logic                   err_q;
  logic                   timeout_q;

  logic req_in_ready, res_in_ready;
  logic issue_fire, res_fire, res_hit, res_drop;
  tag_t res_tag;
  req_t req_in, req_q;
  res_t res_in, res_q;

  assign res_tag = acc_tag_i;

  // Readies are held low in reset so every output reads 0 there. The
  // admission test uses the registered count only, so a result accepted in
  // the same cycle never frees a slot early, and the in-flight check stalls
  // an ID that is being returned this very cycle.
  assign issue_ready_o = rst_ni && !flush_i && req_in_ready
                      && (count < OUT_W'(MAX_OUTSTANDING))
                      && !inflight_q[issue_id_i];
  assign issue_fire    = issue_valid_i && issue_ready_o;

  // During flush results are swallowed: ready is forced high, but neither
  // the result register nor err_o sees them.
  assign acc_ready_o = rst_ni && (flush_i || res_in_ready);
  assign res_fire    = acc_valid_i && acc_ready_o && !flush_i;
  assign res_hit     = res_fire && inflight_q[res_tag.id];
  assign res_drop    = res_fire && !inflight_q[res_tag.id];

  assign req_in = '{rs1: issue_rs1_i, imm: issue_imm_i,
                    tag: '{id: issue_id_i, rd: issue_rd_i}};
  assign res_in = '{data: acc_result_i, rd: res_tag.rd, id: res_tag.id};

  dummy_acc_pipe_reg #(.T(req_t)) u_req_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush     (flush_i),
    .in_valid  (issue_fire),
    .in_ready  (req_in_ready),
    .in_data   (req_in),
    .out_valid (acc_valid_o),
    .out_ready (acc_ready_i),
    .out_data  (req_q)
  );

  dummy_acc_pipe_reg #(.T(res_t)) u_res_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush     (flush_i),
    .in_valid  (res_hit),
    .in_ready  (res_in_ready),
    .in_data   (res_in),
    .out_valid (wb_valid_o),
    .out_ready (wb_ready_i),
    .out_data  (res_q)
  );

  assign acc_rs1_o = req_q.rs1;
  assign acc_imm_o = req_q.imm;
  assign acc_tag_o = req_q.tag;
  assign wb_data_o = res_q.data;
  assign wb_rd_o   = res_q.rd;
  assign wb_id_o   = res_q.id;

  // Issue and hit in one cycle cancel out; only a lone event steps it.
  updown_counter #(.WIDTH(OUT_W)) u_outstanding (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (flush_i),
    .en     (issue_fire ^ res_hit),
    .dn     (res_hit),
    .count  (count)
  );

  // Set and clear never target the same bit: an issuing ID is not in
  // flight, a hitting ID is.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else if (flush_i) begin
      inflight_q <= '0;
    end else begin
      if (issue_fire) inflight_q[issue_id_i] <= 1'b1;
      if (res_hit)    inflight_q[res_tag.id] <= 1'b0;
    end
  end

  // Watchdog: counts idle busy cycles, saturates at WD_LAST and raises
  // timeout_o on the edge where it gets there.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (flush_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (res_drop) err_q <= 1'b1;
      if (count == '0 || res_hit) begin
        wd_q <= '0;
      end else if (wd_q != WD_LAST) begin
        wd_q <= wd_q + WD_W'(1);
        if (wd_q == WD_LAST - WD_W'(1)) timeout_q <= 1'b1;
      end
    end
  end

  assign outstanding_o = count;
  assign busy_o        = (count != '0) || wb_valid_o;
  assign err_o         = err_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_dummy_accelerator_issuer.sv
// Self-checking bench for dummy_accelerator_issuer. The bench plays both the
// core and the accelerator; a transaction-level model (in-flight set, credit
// count, one pending request, one pending writeback, idle-cycle counter)
// predicts every output each cycle.
module tb_dummy_accelerator_issuer;

  localparam int W    = 32;
  localparam int IW   = 11;
  localparam int IDW  = 4;
  localparam int RDW  = 5;
  localparam int MAXO = 4;
  localparam int TO   = 16;
  localparam int CW   = $clog2(MAXO + 1);

  logic           clk = 1'b0;
  logic           rst_ni;
  logic           flush_i;
  logic           issue_valid_i;
  logic           issue_ready_o;
  logic [W-1:0]   issue_rs1_i;
  logic [IW-1:0]  issue_imm_i;
  logic [IDW-1:0] issue_id_i;
  logic [RDW-1:0] issue_rd_i;
  logic           acc_valid_o;
  logic           acc_ready_i;
  logic [W-1:0]   acc_rs1_o;
  logic [IW-1:0]  acc_imm_o;
  logic [IDW+RDW-1:0] acc_tag_o;
  logic           acc_valid_i;
  logic           acc_ready_o;
  logic [W-1:0]   acc_result_i;
  logic [IDW+RDW-1:0] acc_tag_i;
  logic           wb_valid_o;
  logic           wb_ready_i;
  logic [W-1:0]   wb_data_o;
  logic [RDW-1:0] wb_rd_o;
  logic [IDW-1:0] wb_id_o;
  logic [CW-1:0]  outstanding_o;
  logic           busy_o;
  logic           err_o;
  logic           timeout_o;

  dummy_accelerator_issuer #(
    .WIDTH(W), .IMM_WIDTH(IW), .ID_WIDTH(IDW), .RD_WIDTH(RDW),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rs1_i(issue_rs1_i), .issue_imm_i(issue_imm_i),
    .issue_id_i(issue_id_i), .issue_rd_i(issue_rd_i),
    .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
    .acc_rs1_o(acc_rs1_o), .acc_imm_o(acc_imm_o), .acc_tag_o(acc_tag_o),
    .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o),
    .acc_result_i(acc_result_i), .acc_tag_i(acc_tag_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_id_o(wb_id_o),
    .outstanding_o(outstanding_o), .busy_o(busy_o),
    .err_o(err_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit             m_inflight [16];
  int             m_cnt;
  bit             m_req_v;
  logic [W-1:0]   m_req_rs1;
  logic [IW-1:0]  m_req_imm;
  logic [IDW+RDW-1:0] m_req_tag;
  bit             m_wb_v;
  logic [W-1:0]   m_wb_data;
  logic [RDW-1:0] m_wb_rd;
  logic [IDW-1:0] m_wb_id;
  bit             m_err;
  bit             m_to;
  int             m_idle;
  bit             last_iss;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m_inflight[i]) m_inflight[i] = 1'b0;
    m_cnt = 0; m_req_v = 0; m_wb_v = 0; m_err = 0; m_to = 0; m_idle = 0;
  endtask

  task automatic set_idle();
    flush_i = 0; issue_valid_i = 0; issue_rs1_i = '0; issue_imm_i = '0;
    issue_id_i = '0; issue_rd_i = '0; acc_ready_i = 1; acc_valid_i = 0;
    acc_result_i = '0; acc_tag_i = '0; wb_ready_i = 1;
  endtask

  // Called at a falling edge with inputs already applied: compare every
  // output to the model, advance the model through the rising edge, and
  // return at the next falling edge.
  task automatic step();
    bit exp_ir, exp_ar, iss, racc, good;
    logic [IDW-1:0] rid;
    #1;
    exp_ir = !flush_i && (!m_req_v || acc_ready_i) && (m_cnt < MAXO)
             && !m_inflight[issue_id_i];
    exp_ar = flush_i || !m_wb_v || wb_ready_i;
    check("issue_ready", issue_ready_o, exp_ir);
    check("acc_ready", acc_ready_o, exp_ar);
    check("acc_valid", acc_valid_o, m_req_v);
    if (m_req_v) begin
      check("acc_rs1", acc_rs1_o, m_req_rs1);
      check("acc_imm", acc_imm_o, m_req_imm);
      check("acc_tag", acc_tag_o, m_req_tag);
    end
    check("wb_valid", wb_valid_o, m_wb_v);
    if (m_wb_v) begin
      check("wb_data", wb_data_o, m_wb_data);
      check("wb_rd", wb_rd_o, m_wb_rd);
      check("wb_id", wb_id_o, m_wb_id);
    end
    check("outstanding", outstanding_o, m_cnt);
    check("busy", busy_o, (m_cnt != 0) || m_wb_v);
    check("err", err_o, m_err);
    check("timeout", timeout_o, m_to);

    iss  = issue_valid_i && exp_ir;
    racc = acc_valid_i && exp_ar && !flush_i;
    rid  = acc_tag_i[IDW+RDW-1:RDW];
    good = racc && m_inflight[rid];
    last_iss = iss;
    if (flush_i) begin
      model_clear();
    end else begin
      if (m_cnt == 0 || good) m_idle = 0;
      else if (m_idle < TO - 1) m_idle++;
      if (m_idle == TO - 1) m_to = 1;
      if (iss) begin
        m_req_v = 1; m_req_rs1 = issue_rs1_i; m_req_imm = issue_imm_i;
        m_req_tag = {issue_id_i, issue_rd_i};
      end else if (acc_ready_i) begin
        m_req_v = 0;
      end
      if (good) begin
        m_wb_v = 1; m_wb_data = acc_result_i;
        m_wb_rd = acc_tag_i[RDW-1:0]; m_wb_id = rid;
      end else if (wb_ready_i) begin
        m_wb_v = 0;
      end
      if (racc && !good) m_err = 1;
      if (iss)  begin m_inflight[issue_id_i] = 1; m_cnt++; end
      if (good) begin m_inflight[rid] = 0; m_cnt--; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input int id, input int rd, input logic [W-1:0] rs1, input logic [IW-1:0] imm);
    issue_valid_i = 1; issue_id_i = IDW'(id); issue_rd_i = RDW'(rd);
    issue_rs1_i = rs1; issue_imm_i = imm;
  endtask

  task automatic result(input int id, input int rd, input logic [W-1:0] data);
    acc_valid_i = 1; acc_tag_i = {IDW'(id), RDW'(rd)}; acc_result_i = data;
  endtask

  // Return every in-flight ID, each held until the model accepts it.
  task automatic drain();
    issue_valid_i = 0; acc_ready_i = 1; wb_ready_i = 1;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 8 && m_inflight[i]; k++) begin
        result(i, i, $urandom);
        step();
      end
      acc_valid_i = 0;
    end
    step();
    step();
  endtask

  initial begin
    set_idle();
    model_clear();
    rst_ni = 0;
    issue_valid_i = 1;     // readies must still read 0 in reset
    #12;
    check("rst_issue_ready", issue_ready_o, 0);
    check("rst_acc_ready", acc_ready_o, 0);
    check("rst_acc_valid", acc_valid_o, 0);
    check("rst_acc_payload", {acc_rs1_o, acc_imm_o, acc_tag_o}, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_payload", {wb_data_o, wb_rd_o, wb_id_o}, 0);
    check("rst_status", {outstanding_o, busy_o, err_o, timeout_o}, 0);
    @(negedge clk);
    rst_ni = 1;
    set_idle();
    step();

    // Single op: id 3, rd 7; accelerator computes rs1 - imm.
    issue(3, 7, 32'h0000_00FF, 11'h00F);
    step();
    issue_valid_i = 0;
    #1;
    check("single_acc_valid", acc_valid_o, 1);
    check("single_acc_tag", acc_tag_o, {4'd3, 5'd7});
    step();
    result(3, 7, 32'h0000_00FF - 32'h0000_000F);
    step();
    acc_valid_i = 0;
    #1;
    check("single_wb_data", wb_data_o, 32'h0000_00F0);
    check("single_wb_rd", wb_rd_o, 7);
    check("single_wb_id", wb_id_o, 3);
    step();
    #1;
    check("single_idle_out", outstanding_o, 0);
    check("single_idle_busy", busy_o, 0);

    // Credit limit: ids 0..3 fill the credits, id 4 waits for a return.
    for (int i = 0; i < 4; i++) begin
      issue(i, i + 1, $urandom, $urandom);
      step();
    end
    issue(4, 5, 32'h1234_5678, 11'h055);
    #1;
    check("credit_full", outstanding_o, MAXO);
    step();
    step();
    result(0, 1, 32'hCAFE_0000);
    step();                           // same-cycle return does not free it
    acc_valid_i = 0;
    #1;
    check("credit_freed", issue_ready_o, 1);
    step();
    check("credit_id4_taken", last_iss, 1);
    issue_valid_i = 0;
    drain();

    // Duplicate ID: id 5 held off until its result is accepted.
    issue(5, 9, 32'hAAAA_5555, 11'h100);
    step();
    step();
    step();
    result(5, 9, 32'h0BAD_F00D);
    step();                           // no bypass: still stalled this cycle
    acc_valid_i = 0;
    #1;
    check("dup_reaccept", issue_ready_o, 1);
    step();
    issue_valid_i = 0;

    // Spurious result for id 9 while id 5 is in flight.
    result(9, 2, 32'hDEAD_BEEF);
    #1;
    check("spurious_ready", acc_ready_o, 1);
    step();
    acc_valid_i = 0;
    #1;
    check("spurious_err", err_o, 1);
    check("spurious_no_wb", wb_valid_o, 0);
    check("spurious_count", outstanding_o, 1);
    step();
    step();
    drain();

    // Backpressure: two results pending behind a stalled writeback.
    issue(1, 11, 32'h1, 11'h1);
    step();
    issue(2, 12, 32'h2, 11'h2);
    step();
    issue_valid_i = 0;
    wb_ready_i = 0;
    result(1, 11, 32'h1111_1111);
    step();
    result(2, 12, 32'h2222_2222);
    for (int i = 0; i < 4; i++) step();
    wb_ready_i = 1;
    step();
    acc_valid_i = 0;
    #1;
    check("bp_second_in_order", wb_data_o, 32'h2222_2222);
    step();
    step();

    // Timeout then flush.
    flush_i = 1;
    step();
    flush_i = 0;
    issue(6, 3, 32'h6666, 11'h66);
    step();
    issue_valid_i = 0;
    for (int i = 0; i < 20; i++) step();
    check("timeout_set", timeout_o, 1);
    flush_i = 1;
    result(6, 3, 32'h0);              // discarded, no error
    step();
    flush_i = 0;
    acc_valid_i = 0;
    #1;
    check("flush_timeout", timeout_o, 0);
    check("flush_count", outstanding_o, 0);
    check("flush_acc_valid", acc_valid_o, 0);
    check("flush_err", err_o, 0);
    issue(6, 3, 32'h6666, 11'h66);
    #1;
    check("flush_reaccept", issue_ready_o, 1);
    step();
    issue_valid_i = 0;
    drain();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      int id;
      flush_i       = ($urandom_range(0, 49) == 0);
      issue_valid_i = $urandom_range(0, 1);
      issue_id_i    = IDW'($urandom_range(0, 15));
      issue_rd_i    = RDW'($urandom);
      issue_rs1_i   = $urandom;
      issue_imm_i   = IW'($urandom);
      acc_ready_i   = ($urandom_range(0, 3) != 0);
      wb_ready_i    = ($urandom_range(0, 3) != 0);
      acc_valid_i   = $urandom_range(0, 1);
      id = $urandom_range(0, 15);
      for (int t = 0; t < 4 && !m_inflight[id]; t++) id = $urandom_range(0, 15);
      acc_tag_i     = {IDW'(id), RDW'($urandom)};
      acc_result_i  = $urandom;
      step();
    end
    set_idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
